// File: rtl/pll_freq_ctrl_pkg.sv
// pll_freq_ctrl_pkg
//   Shared types and helpers for the PLL frequency-lock controller.
//   pfc_state_e : controller FSM states
//   pfc_abs     : magnitude of a 32-bit signed value
//   pfc_min     : smaller of two 32-bit unsigned values
package pll_freq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    EVAL,
    ADJUST,
    SETTLE
  } pfc_state_e;

  function automatic logic [31:0] pfc_abs(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] pfc_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_freq_ctrl_if.sv
// pll_freq_ctrl_if
//   Control/status bundle of pll_freq_ctrl.
//   en_i, stable_cfg_i          : loop enable and configuration-stable qualifiers
//   win_len_i, target_i         : window length and expected tick count
//   fb_tick_i                   : synchronised feedback tick
//   freq_incr_o, freq_decr_o    : vco adjust pulses
//   locked_o, meas_cnt_o        : lock flag and last completed window count
//   clr_i, lock_lost_o          : only with PLL_FREQ_CTRL_LOSS_EN defined
//   master drives the inputs (system side), slave is the controller.
interface pll_freq_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             en_i;
  logic             stable_cfg_i;
  logic [CNT_W-1:0] win_len_i;
  logic [CNT_W-1:0] target_i;
  logic             fb_tick_i;
  logic             freq_incr_o;
  logic             freq_decr_o;
  logic             locked_o;
  logic [CNT_W-1:0] meas_cnt_o;
`ifdef PLL_FREQ_CTRL_LOSS_EN
  logic             clr_i;
  logic             lock_lost_o;

  modport master (
    output en_i, stable_cfg_i, win_len_i, target_i, fb_tick_i, clr_i,
    input  freq_incr_o, freq_decr_o, locked_o, meas_cnt_o, lock_lost_o
  );
  modport slave (
    input  en_i, stable_cfg_i, win_len_i, target_i, fb_tick_i, clr_i,
    output freq_incr_o, freq_decr_o, locked_o, meas_cnt_o, lock_lost_o
  );
`else
  modport master (
    output en_i, stable_cfg_i, win_len_i, target_i, fb_tick_i,
    input  freq_incr_o, freq_decr_o, locked_o, meas_cnt_o
  );
  modport slave (
    input  en_i, stable_cfg_i, win_len_i, target_i, fb_tick_i,
    output freq_incr_o, freq_decr_o, locked_o, meas_cnt_o
  );
`endif

endinterface

// File: rtl/pll_win_counter.sv
// pll_win_counter
//   Window timer plus saturating feedback-tick counter.
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   i_start        : load timer with max(i_win_len,1) and clear the count;
//                    counting starts on the following cycle
//   i_abort        : drop any window in progress and clear timer/count
//   i_win_len      : window length in clock cycles (0 behaves as 1)
//   i_tick         : feedback tick, counted on every cycle of the window
//   o_done         : high on the last cycle of the window
//   o_count        : tick count; holds its value after the window ends
module pll_win_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_win_len,
  input  logic             i_tick,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  logic             r_active;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_active <= 1'b0;
      r_timer  <= '0;
      r_count  <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_timer  <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_timer  <= (i_win_len == '0) ? CNT_W'(1) : i_win_len;
      r_count  <= '0;
    end else if (r_active) begin
      if (r_count != '1) begin
        r_count <= r_count + CNT_W'(i_tick);
      end
      if (r_timer == CNT_W'(1)) begin
        r_active <= 1'b0;
      end else begin
        r_timer <= r_timer - CNT_W'(1);
      end
    end
  end

  assign o_done  = r_active & (r_timer == CNT_W'(1));
  assign o_count = r_count;

endmodule

// File: rtl/pll_freq_ctrl.sv
// pll_freq_ctrl
//   Digital frequency-lock controller around the vco. Counts feedback ticks
//   over a window, compares against a target and emits incr/decr pulses of
//   min(|error|, MAX_STEP) cycles, followed by SETTLE_CYC quiet cycles.
//   locked_o rises after LOCK_CNT consecutive windows within +/-TOL.
//   Ports: clk_i, arst_ni (async active-low), bus (pll_freq_ctrl_if.slave).
//   Optional feature macro PLL_FREQ_CTRL_LOSS_EN: adds clr_i / lock_lost_o,
//   a sticky flag set whenever locked_o falls other than by reset.
//   MAX_STEP and SETTLE_CYC must be at least 1.
module pll_freq_ctrl
  import pll_freq_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LOCK_CNT   = 16,
  parameter int TOL        = 2,
  parameter int MAX_STEP   = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  pll_freq_ctrl_if.slave bus
);

  localparam int PH_MAX = (MAX_STEP > SETTLE_CYC) ? MAX_STEP : SETTLE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int LC_W   = $clog2(LOCK_CNT + 1);

  pfc_state_e          r_state;
  logic [PH_W-1:0]     r_phase;
  logic [LC_W-1:0]     r_lock_cnt;
  logic                r_incr;
  logic                r_decr;
  logic                r_locked;
  logic [CNT_W-1:0]    r_meas;

  logic                w_run;
  logic                w_start;
  logic                w_done;
  logic [CNT_W-1:0]    w_count;
  logic signed [CNT_W:0] w_err;
  logic [31:0]         w_abs;
  logic                w_good;
  logic                w_neg;
  logic [LC_W-1:0]     w_lock_inc;

  assign w_run = bus.en_i & bus.stable_cfg_i;

  // A new window is armed in the cycle before MEASURE so that the counter
  // sees every MEASURE cycle, including the first.
  assign w_start = w_run & ((r_state == IDLE) ||
                            ((r_state == EVAL) && w_good) ||
                            ((r_state == SETTLE) && (r_phase == PH_W'(1))));

  pll_win_counter #(
    .CNT_W (CNT_W)
  ) u_win (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .i_start   (w_start),
    .i_abort   (~w_run),
    .i_win_len (bus.win_len_i),
    .i_tick    (bus.fb_tick_i),
    .o_done    (w_done),
    .o_count   (w_count)
  );

  assign w_err      = $signed({1'b0, w_count}) - $signed({1'b0, bus.target_i});
  assign w_neg      = w_err[CNT_W];
  assign w_abs      = pfc_abs(32'(w_err));
  assign w_good     = (w_abs <= 32'(TOL));
  assign w_lock_inc = (r_lock_cnt == LC_W'(LOCK_CNT)) ? r_lock_cnt : r_lock_cnt + LC_W'(1);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_lock_cnt <= '0;
      r_incr     <= 1'b0;
      r_decr     <= 1'b0;
      r_locked   <= 1'b0;
      r_meas     <= '0;
    end else if (!w_run) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_lock_cnt <= '0;
      r_incr     <= 1'b0;
      r_decr     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= MEASURE;
        MEASURE: begin
          if (w_done) begin
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_meas <= w_count;
          if (w_good) begin
            r_lock_cnt <= w_lock_inc;
            r_locked   <= (w_lock_inc == LC_W'(LOCK_CNT));
            r_state    <= MEASURE;
          end else begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_phase    <= PH_W'(pfc_min(w_abs, 32'(MAX_STEP)));
            r_incr     <= w_neg;
            r_decr     <= ~w_neg;
            r_state    <= ADJUST;
          end
        end
        ADJUST: begin
          if (r_phase == PH_W'(1)) begin
            r_incr  <= 1'b0;
            r_decr  <= 1'b0;
            r_phase <= PH_W'(SETTLE_CYC);
            r_state <= SETTLE;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        SETTLE: begin
          if (r_phase == PH_W'(1)) begin
            r_state <= MEASURE;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.freq_incr_o = r_incr;
  assign bus.freq_decr_o = r_decr;
  assign bus.locked_o    = r_locked;
  assign bus.meas_cnt_o  = r_meas;

`ifdef PLL_FREQ_CTRL_LOSS_EN
  logic r_lost;

  // locked_o only falls on a disable or on a bad window evaluation.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_lost <= 1'b0;
    end else if (r_locked && (!w_run || ((r_state == EVAL) && !w_good))) begin
      r_lost <= 1'b1;
    end else if (bus.clr_i) begin
      r_lost <= 1'b0;
    end
  end

  assign bus.lock_lost_o = r_lost;
`endif

endmodule
